// File: rtl/ds_sample_fifo.sv
// ---------------------------------------------------------------------------
// ds_sample_fifo
//   Sample FIFO feeding the delta-sigma modulator. The bus side pushes signed
//   NBIT samples and the modulator pops one per OSR period. The oldest entry
//   is shown ahead on o_data with no latency. When the FIFO is empty, o_data
//   holds the last popped sample, so the modulator never sees a step to an
//   undefined value.
//
//   Optional feature macro: DS_SAMPLE_FIFO_IRQ_EN
//     Defined     : registered almost-empty interrupt on o_irq_ae.
//     Not defined : o_irq_ae tied to 0 and no extra flops are built.
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_rst_n      asynchronous reset, active low
//   i_clr        synchronous flush of pointers and level (memory and last
//                sample are kept)
//   i_wr         push strobe
//   i_wr_data    sample to push
//   o_full       level == 2**DEPTH_LOG2
//   i_rd         pop strobe from the modulator
//   o_data       oldest entry, or the last popped sample when empty
//   o_empty      level == 0
//   o_level      number of stored entries, 0..2**DEPTH_LOG2
//   o_overflow   sticky: push attempted while full and not popping
//   o_underflow  sticky: pop attempted while empty
//   i_clr_flags  synchronous clear of the sticky flags (and of o_irq_ae)
//   o_irq_ae     almost-empty interrupt
// ---------------------------------------------------------------------------
module ds_sample_fifo #(
    parameter int NBIT       = 30,
    parameter int DEPTH_LOG2 = 3,
    parameter int AE_THRESH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_wr,
    input  logic [NBIT-1:0]       i_wr_data,
    output logic                  o_full,
    input  logic                  i_rd,
    output logic [NBIT-1:0]       o_data,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow,
    output logic                  o_underflow,
    input  logic                  i_clr_flags,
    output logic                  o_irq_ae
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_AE   = (DEPTH_LOG2+1)'(AE_THRESH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2+1)'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = (DEPTH_LOG2)'(0);

    logic [NBIT-1:0]       mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   level_r;
    logic [DEPTH_LOG2:0]   level_nxt_s;
    logic [NBIT-1:0]       last_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic full_s;
    logic empty_s;
    logic pop_acc_s;
    logic wr_acc_s;
    logic ovf_ev_s;
    logic udf_ev_s;

    assign full_s    = (level_r == LVL_FULL);
    assign empty_s   = (level_r == LVL_ZERO);
    assign pop_acc_s = i_rd && !empty_s;
    // A push into a full FIFO fits only when a pop frees a slot in the same cycle.
    assign wr_acc_s  = i_wr && (!full_s || pop_acc_s);
    // A flush overrides push/pop, so it also suppresses their error events.
    assign ovf_ev_s  = i_wr && !wr_acc_s && !i_clr;
    assign udf_ev_s  = i_rd && empty_s && !i_clr;

    // Next fill level from the accepted push/pop pair.
    always_comb begin
        level_nxt_s = level_r;
        case ({wr_acc_s, pop_acc_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Show-ahead read port, falls back to the last popped sample when empty.
    always_comb begin
        if (empty_s) begin
            o_data = last_r;
        end else begin
            o_data = mem_r[rd_ptr_r];
        end
    end

    // Pointer and level registers; flush has priority over push/pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else if (i_clr) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (wr_acc_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_acc_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            level_r <= level_nxt_s;
        end
    end

    // Sample storage; contents are not reset since only valid entries are ever shown.
    always_ff @(posedge i_clk) begin
        if (wr_acc_s && !i_clr) begin
            mem_r[wr_ptr_r] <= i_wr_data;
        end
    end

    // Last popped sample, kept across flushes so the modulator sees no step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_r <= {NBIT{1'b0}};
        end else if (pop_acc_s && !i_clr) begin
            last_r <= mem_r[rd_ptr_r];
        end
    end

    // Sticky error flags; a new event beats a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (ovf_ev_s) overflow_r <= 1'b1;
            else if (i_clr_flags) overflow_r <= 1'b0;
            if (udf_ev_s) underflow_r <= 1'b1;
            else if (i_clr_flags) underflow_r <= 1'b0;
        end
    end

    assign o_full      = full_s;
    assign o_empty     = empty_s;
    assign o_level     = level_r;
    assign o_overflow  = overflow_r;
    assign o_underflow = underflow_r;

`ifdef DS_SAMPLE_FIFO_IRQ_EN
    logic above_r;
    logic irq_r;

    // Almost-empty interrupt: fires one cycle after the level drops from above
    // the threshold to at/below it; re-arms only once the level rises again.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            above_r <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            above_r <= (level_r > LVL_AE);
            if (above_r && (level_r <= LVL_AE)) irq_r <= 1'b1;
            else if (i_clr_flags) irq_r <= 1'b0;
        end
    end

    assign o_irq_ae = irq_r;
`else
    assign o_irq_ae = 1'b0;
`endif

endmodule
